// File: rtl/vga_draw_if.sv
// Draw-request bus between the CPU-side datapath and the VGA draw unit.
interface vga_draw_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_mode;
    logic [14:0] req_color;
    logic [7:0]  req_x;
    logic [6:0]  req_y;
    logic [7:0]  req_w;
    logic [6:0]  req_h;

    modport master (output req_valid, req_mode, req_color, req_x, req_y, req_w, req_h,
                    input  req_ready);
    modport slave  (input  req_valid, req_mode, req_color, req_x, req_y, req_w, req_h,
                    output req_ready);
endinterface

// File: rtl/vga_draw_unit.sv
// Rasterises pixel / rectangle / clear requests into one plot strobe per clock.
module vga_draw_unit #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic        clock,
    input  logic        resetn,
    vga_draw_if.slave   bus,
    output logic        vga_plot,
    output logic [7:0]  vga_out_x,
    output logic [6:0]  vga_out_y,
    output logic [14:0] vga_out_color,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, DRAW, FINISH} state_t;

    state_t      state, nxt_state;
    logic [14:0] col, nxt_col;
    logic [7:0]  x0, nxt_x0, w, nxt_w, dx, nxt_dx;
    logic [6:0]  y0, nxt_y0, h, nxt_h, dy, nxt_dy;
    logic [8:0]  px;
    logic [7:0]  py;

    // Status outputs decode straight from the state register.
    assign bus.req_ready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign done          = (state == FINISH);

    // Next-state, request latching and raster stepping.
    always_comb begin
        nxt_state = state;
        nxt_col   = col;
        nxt_x0    = x0;
        nxt_y0    = y0;
        nxt_w     = w;
        nxt_h     = h;
        nxt_dx    = dx;
        nxt_dy    = dy;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    nxt_col = bus.req_color;
                    nxt_x0  = bus.req_x;
                    nxt_y0  = bus.req_y;
                    nxt_dx  = '0;
                    nxt_dy  = '0;
                    case (bus.req_mode)
                        2'd0: begin nxt_w = 8'd1; nxt_h = 7'd1; end
                        2'd1: begin nxt_w = bus.req_w; nxt_h = bus.req_h; end
                        2'd2: begin
                            nxt_x0 = '0;
                            nxt_y0 = '0;
                            nxt_w  = 8'(SCREEN_W);
                            nxt_h  = 7'(SCREEN_H);
                        end
                        default: begin nxt_w = '0; nxt_h = '0; end
                    endcase
                    // Empty extents and the reserved mode still complete with a done pulse.
                    if (nxt_w == '0 || nxt_h == '0) nxt_state = FINISH;
                    else                            nxt_state = DRAW;
                end
            end
            DRAW: begin
                if (dx == w - 8'd1) begin
                    nxt_dx = '0;
                    if (dy == h - 7'd1) nxt_state = FINISH;
                    else                nxt_dy = dy + 7'd1;
                end else begin
                    nxt_dx = dx + 8'd1;
                end
            end
            FINISH:  nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
        // Widened sums so pixels past the right/bottom edge are detected, not wrapped.
        px = {1'b0, nxt_x0} + {1'b0, nxt_dx};
        py = {1'b0, nxt_y0} + {1'b0, nxt_dy};
    end

    // State, latched request fields and raster counters.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
            col   <= '0;
            x0    <= '0;
            y0    <= '0;
            w     <= '0;
            h     <= '0;
            dx    <= '0;
            dy    <= '0;
        end else begin
            state <= nxt_state;
            col   <= nxt_col;
            x0    <= nxt_x0;
            y0    <= nxt_y0;
            w     <= nxt_w;
            h     <= nxt_h;
            dx    <= nxt_dx;
            dy    <= nxt_dy;
        end
    end

    // Registered pixel outputs: loaded for the pixel of the coming DRAW cycle, held otherwise.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            vga_plot      <= 1'b0;
            vga_out_x     <= '0;
            vga_out_y     <= '0;
            vga_out_color <= '0;
        end else begin
            vga_plot <= (nxt_state == DRAW) && (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));
            if (nxt_state == DRAW) begin
                vga_out_x     <= px[7:0];
                vga_out_y     <= py[6:0];
                vga_out_color <= nxt_col;
            end
        end
    end
endmodule
